// File: rtl/elevador_pkg.sv
// Shared definitions for the elevator occupancy counter.
//   estado_ocupacao_t : occupancy FSM encoding as seen on estado_ocupacao.
//   ESTADO_ILEGAL     : the unused code, kept named so recovery logic reads clearly.
package elevador_pkg;

    typedef enum logic [1:0] {
        VAZIO   = 2'b00,
        OCUPADO = 2'b01,
        LOTADO  = 2'b10
    } estado_ocupacao_t;

    localparam logic [1:0] ESTADO_ILEGAL = 2'b11;

endpackage : elevador_pkg

// File: rtl/detector_borda_subida.sv
// Rising-edge detector for an already-debounced level input.
//   clock   : system clock
//   reset   : synchronous, active-high; history is forced to 1
//   entrada : level input
//   pulso   : one-cycle pulse in the cycle the input rises
// The history register resets to 1, so a level already high when reset is
// released is not seen as a new edge.
module detector_borda_subida (
    input  logic clock,
    input  logic reset,
    input  logic entrada,
    output logic pulso
);

    logic hist_q;
    logic hist_d;

    always_comb begin
        hist_d = entrada;
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign pulso = entrada & ~hist_q;

endmodule : detector_borda_subida

// File: rtl/contador_ocupacao_elevador.sv
// Elevator occupancy counter with edge-detected buttons and door gating.
//   clock, reset         : system clock, synchronous active-high reset
//   botao_subir          : board request (debounced level)
//   botao_descer         : leave request (debounced level)
//   porta_aberta         : events are accepted only while high
//   quantidade_pessoas   : registered passenger count, 0..CAPACIDADE
//   estado_ocupacao      : registered FSM state (VAZIO/OCUPADO/LOTADO)
//   vazio, lotado        : decoded from the registered state
//   alerta_excesso       : latched, boarding rejected while full
//   alerta_erro          : one-cycle pulse, leave request while empty
module contador_ocupacao_elevador
    import elevador_pkg::*;
#(
    parameter  int CAPACIDADE = 3,
    localparam int LARGURA    = $clog2(CAPACIDADE + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               botao_subir,
    input  logic               botao_descer,
    input  logic               porta_aberta,
    output logic [LARGURA-1:0] quantidade_pessoas,
    output logic [1:0]         estado_ocupacao,
    output logic               vazio,
    output logic               lotado,
    output logic               alerta_excesso,
    output logic               alerta_erro
);

    localparam logic [LARGURA-1:0] CAP_L = LARGURA'(CAPACIDADE);

    logic ev_sub;
    logic ev_des;

    detector_borda_subida u_borda_sub (
        .clock   (clock),
        .reset   (reset),
        .entrada (botao_subir),
        .pulso   (ev_sub)
    );

    detector_borda_subida u_borda_des (
        .clock   (clock),
        .reset   (reset),
        .entrada (botao_descer),
        .pulso   (ev_des)
    );

    logic [LARGURA-1:0] count_q,   count_d;
    logic [1:0]         estado_q;
    estado_ocupacao_t   estado_d;
    logic               excesso_q, excesso_d;
    logic               erro_q,    erro_d;

    logic entra;
    logic sai;
    logic cheio;
    logic sem_ninguem;
    logic set_excesso;
    logic clr_excesso;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        count_d   = count_q;
        estado_d  = VAZIO;
        excesso_d = excesso_q;
        erro_d    = 1'b0;

        // Simultaneous in+out cancel: one passenger swapped, nothing to do.
        entra       = ev_sub & porta_aberta & ~(ev_des & porta_aberta);
        sai         = ev_des & porta_aberta & ~(ev_sub & porta_aberta);
        cheio       = (count_q == CAP_L);
        sem_ninguem = (count_q == '0);

        set_excesso = entra & cheio;
        clr_excesso = (sai & ~sem_ninguem) | ~porta_aberta;

        if (entra && !cheio) begin
            count_d = count_q + LARGURA'(1);
        end else if (sai && !sem_ninguem) begin
            count_d = count_q - LARGURA'(1);
        end

        erro_d    = sai & sem_ninguem;
        excesso_d = set_excesso | (excesso_q & ~clr_excesso);

        // State follows the next count, which covers every legal transition
        // including the CAPACIDADE = 1 shortcuts VAZIO <-> LOTADO.
        if (count_d == '0) begin
            estado_d = VAZIO;
        end else if (count_d == CAP_L) begin
            estado_d = LOTADO;
        end else begin
            estado_d = OCUPADO;
        end

        // The unused code means state was corrupted; restart from a known
        // empty car rather than trust the count.
        if (estado_q == ESTADO_ILEGAL) begin
            count_d   = '0;
            estado_d  = VAZIO;
            excesso_d = 1'b0;
            erro_d    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q   <= '0;
            estado_q  <= VAZIO;
            excesso_q <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            estado_q  <= estado_d;
            excesso_q <= excesso_d;
            erro_q    <= erro_d;
        end
    end

    assign quantidade_pessoas = count_q;
    assign estado_ocupacao    = estado_q;
    assign vazio              = (estado_q == VAZIO);
    assign lotado             = (estado_q == LOTADO);
    assign alerta_excesso     = excesso_q;
    assign alerta_erro        = erro_q;

endmodule : contador_ocupacao_elevador

// File: tb/tb_contador_ocupacao_elevador.sv
// Self-checking bench for contador_ocupacao_elevador (CAPACIDADE = 3).
// A behavioural model tracks the passenger count as a plain integer and
// derives every expected output from it; directed scenarios are followed by
// a randomized run.
module tb_contador_ocupacao_elevador;

    localparam int CAP = 3;
    localparam int W   = $clog2(CAP + 1);

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         botao_subir = 1'b0;
    logic         botao_descer = 1'b0;
    logic         porta_aberta = 1'b0;
    logic [W-1:0] quantidade_pessoas;
    logic [1:0]   estado_ocupacao;
    logic         vazio;
    logic         lotado;
    logic         alerta_excesso;
    logic         alerta_erro;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_count = 0;
    bit m_exc   = 0;
    bit m_err   = 0;
    bit m_prev_sub = 1;
    bit m_prev_des = 1;

    always #5 clock = ~clock;

    contador_ocupacao_elevador #(.CAPACIDADE(CAP)) dut (
        .clock              (clock),
        .reset              (reset),
        .botao_subir        (botao_subir),
        .botao_descer       (botao_descer),
        .porta_aberta       (porta_aberta),
        .quantidade_pessoas (quantidade_pessoas),
        .estado_ocupacao    (estado_ocupacao),
        .vazio              (vazio),
        .lotado             (lotado),
        .alerta_excesso     (alerta_excesso),
        .alerta_erro        (alerta_erro)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the rules of the
    // block, then compare every output just after the clock edge.
    task automatic step(input bit sub, input bit des, input bit door, input bit rst);
        bit nova_sub, nova_des, ok_sub, ok_des, set_e, clr_e;
        int exp_estado;
        botao_subir  = sub;
        botao_descer = des;
        porta_aberta = door;
        reset        = rst;

        if (rst) begin
            m_count = 0; m_exc = 0; m_err = 0;
            m_prev_sub = 1; m_prev_des = 1;
        end else begin
            nova_sub = sub && !m_prev_sub;
            nova_des = des && !m_prev_des;
            m_prev_sub = sub;
            m_prev_des = des;
            ok_sub = nova_sub && door;
            ok_des = nova_des && door;
            m_err = 0;
            set_e = 0;
            clr_e = !door;
            if (ok_sub && !ok_des) begin
                if (m_count < CAP) m_count++;
                else set_e = 1;
            end else if (ok_des && !ok_sub) begin
                if (m_count > 0) begin
                    m_count--;
                    clr_e = 1;
                end else begin
                    m_err = 1;
                end
            end
            m_exc = set_e || (m_exc && !clr_e);
        end

        @(posedge clock);
        #1;
        exp_estado = (m_count == 0) ? 0 : (m_count == CAP) ? 2 : 1;
        check("quantidade", int'(quantidade_pessoas), m_count);
        check("estado",     int'(estado_ocupacao),    exp_estado);
        check("vazio",      int'(vazio),              int'(m_count == 0));
        check("lotado",     int'(lotado),             int'(m_count == CAP));
        check("excesso",    int'(alerta_excesso),     int'(m_exc));
        check("erro",       int'(alerta_erro),        int'(m_err));
    endtask

    task automatic pulso_sub(input bit door);
        step(1, 0, door, 0);
        step(0, 0, door, 0);
    endtask

    task automatic pulso_des(input bit door);
        step(0, 1, door, 0);
        step(0, 0, door, 0);
    endtask

    initial begin
        // Reset and idle so history registers see a low level
        step(0, 0, 0, 1);
        check("reset_count",  int'(quantidade_pessoas), 0);
        check("reset_vazio",  int'(vazio), 1);
        check("reset_lotado", int'(lotado), 0);
        step(0, 0, 1, 0);

        // Fill to capacity
        pulso_sub(1);
        pulso_sub(1);
        check("plan_ocupado", int'(estado_ocupacao), 1);
        pulso_sub(1);
        check("plan_cheio",   int'(quantidade_pessoas), 3);
        check("plan_lotado",  int'(lotado), 1);

        // Overflow attempt, then an exit clears the alert
        pulso_sub(1);
        check("plan_excesso", int'(alerta_excesso), 1);
        check("plan_sem_wrap", int'(quantidade_pessoas), 3);
        pulso_des(1);
        check("plan_exc_limpo", int'(alerta_excesso), 0);
        check("plan_dois", int'(quantidade_pessoas), 2);

        // Both buttons rise together at count 2
        step(1, 1, 1, 0);
        step(0, 0, 1, 0);
        check("plan_simult", int'(quantidade_pessoas), 2);

        // Button held for 10 cycles: exactly one increment
        for (int i = 0; i < 10; i++) step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        check("plan_segurado", int'(quantidade_pessoas), 3);

        // Empty the car, then a leave request while empty
        pulso_des(1); pulso_des(1); pulso_des(1);
        step(0, 1, 1, 0);
        check("plan_erro_pulso", int'(alerta_erro), 1);
        step(0, 0, 1, 0);
        check("plan_erro_um_ciclo", int'(alerta_erro), 0);

        // Door closed: both pulses dropped; opening with subir held does nothing
        step(1, 1, 0, 0);
        step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        check("plan_porta", int'(quantidade_pessoas), 0);

        // Reset mid-operation with a rising button
        pulso_sub(1); pulso_sub(1);
        step(1, 0, 1, 1);
        check("plan_reset_meio", int'(quantidade_pessoas), 0);
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        check("plan_reset_segurado", int'(quantidade_pessoas), 0);

        // Randomized run; buttons toggle often, door mostly open
        for (int i = 0; i < 3000; i++) begin
            step(bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)),
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_contador_ocupacao_elevador
